// File: rtl/spi_flash_responder_if.sv
// Byte-fetch port between the flash responder (master) and its backing memory (slave).
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemAck;
    logic [7:0]        MemData;

    modport master (output MemReq, output MemAddr, input MemAck, input MemData);
    modport slave  (input MemReq, input MemAddr, output MemAck, output MemData);
endinterface

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash target answering READ (0x03) and dual-output fast read (0x3B).
// SPI pins are oversampled on C25M; bytes are prefetched over a req/ack memory port.
module spi_flash_responder #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned DUMMY_CLKS = 8
) (
    input  logic C25M,
    input  logic RES,
    input  logic nFCS,
    input  logic FCK,
    input  logic MOSIin,
    output logic MISOout,
    output logic MISOOE,
    output logic MOSIout,
    output logic MOSIOE,
    output logic Busy,
    output logic Underrun,
    spi_flash_responder_if.master mem
);

    localparam int unsigned DummyW = $clog2(DUMMY_CLKS + 1);
    localparam int unsigned CntW   = (DummyW > 5) ? DummyW : 5;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StIgnore} stateE;

    logic [1:0] nfcsSync, fckSync, mosiSync;
    logic       fckPrev;
    logic       csHigh, fckRise, fckFall, mosiS;

    stateE             stateQ, stateD;
    logic [CntW-1:0]   bitCntQ, bitCntD;
    logic [22:0]       shiftInQ, shiftInD;
    logic              dualQ, dualD;
    logic [ADDR_W-1:0] addrCntQ, addrCntD;
    logic [ADDR_W-1:0] memAddrQ, memAddrD;
    logic              memReqQ, memReqD;
    logic              discardQ, discardD;
    logic [7:0]        bufQ, bufD;
    logic              bufValidQ, bufValidD;
    logic [7:0]        shiftOutQ, shiftOutD;
    logic              misoQ, misoD, mosiQ, mosiD;
    logic              underrunQ, underrunD;

    logic [23:0]       rxWord;
    logic [7:0]        loadByte, curByte;
    logic              accept, fetching;

    always_ff @(posedge C25M) begin
        if (RES) begin
            nfcsSync <= 2'b11;
            fckSync  <= 2'b00;
            mosiSync <= 2'b00;
            fckPrev  <= 1'b0;
        end else begin
            nfcsSync <= {nfcsSync[0], nFCS};
            fckSync  <= {fckSync[0], FCK};
            mosiSync <= {mosiSync[0], MOSIin};
            fckPrev  <= fckSync[1];
        end
    end

    assign csHigh  = nfcsSync[1];
    assign fckRise = fckSync[1] & ~fckPrev;
    assign fckFall = ~fckSync[1] & fckPrev;
    assign mosiS   = mosiSync[1];

    always_comb begin
        stateD    = stateQ;
        bitCntD   = bitCntQ;
        shiftInD  = shiftInQ;
        dualD     = dualQ;
        addrCntD  = addrCntQ;
        memAddrD  = memAddrQ;
        memReqD   = memReqQ;
        discardD  = discardQ;
        bufD      = bufQ;
        bufValidD = bufValidQ;
        shiftOutD = shiftOutQ;
        misoD     = misoQ;
        mosiD     = mosiQ;
        underrunD = underrunQ;
        rxWord    = {shiftInQ, mosiS};
        loadByte  = 8'hFF;
        curByte   = shiftOutQ;
        accept    = 1'b0;
        fetching  = (stateQ == StDummy) || (stateQ == StData);

        // Acks for a fetch left over from an aborted transfer are swallowed.
        if (memReqQ && mem.MemAck) begin
            memReqD  = 1'b0;
            discardD = 1'b0;
            accept   = !discardQ && !csHigh && fetching;
            if (accept) begin
                bufD      = mem.MemData;
                bufValidD = 1'b1;
                addrCntD  = addrCntQ + ADDR_W'(1);
            end
        end

        if (csHigh) begin
            if (stateQ != StIdle) begin
                stateD = StIdle;
                misoD  = 1'b1;
                mosiD  = 1'b1;
            end
            bufValidD = 1'b0;
            bitCntD   = '0;
            if (memReqQ && !mem.MemAck) begin
                discardD = 1'b1;
            end
        end else begin
            case (stateQ)
                StIdle: begin
                    stateD  = StCmd;
                    bitCntD = '0;
                end
                StCmd: begin
                    if (fckRise) begin
                        shiftInD = rxWord[22:0];
                        bitCntD  = bitCntQ + CntW'(1);
                        if (bitCntQ == CntW'(7)) begin
                            bitCntD = '0;
                            if (rxWord[7:0] == 8'h03) begin
                                stateD = StAddr;
                                dualD  = 1'b0;
                            end else if (rxWord[7:0] == 8'h3B) begin
                                stateD = StAddr;
                                dualD  = 1'b1;
                            end else begin
                                stateD = StIgnore;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (fckRise) begin
                        shiftInD = rxWord[22:0];
                        bitCntD  = bitCntQ + CntW'(1);
                        if (bitCntQ == CntW'(23)) begin
                            bitCntD  = '0;
                            addrCntD = rxWord[ADDR_W-1:0];
                            if (!memReqQ) begin
                                memReqD  = 1'b1;
                                memAddrD = rxWord[ADDR_W-1:0];
                            end
                            stateD = dualQ ? StDummy : StData;
                        end
                    end
                end
                StDummy: begin
                    if (fckRise) begin
                        bitCntD = bitCntQ + CntW'(1);
                        if (bitCntQ == CntW'(DUMMY_CLKS - 1)) begin
                            bitCntD = '0;
                            stateD  = StData;
                        end
                    end
                end
                StData: begin
                    if (fckFall) begin
                        if (bitCntQ == '0) begin
                            // A same-cycle ack bypasses the buffer straight into the shifter.
                            if (accept) begin
                                loadByte = mem.MemData;
                            end else if (bufValidQ) begin
                                loadByte = bufQ;
                            end else begin
                                loadByte  = 8'hFF;
                                underrunD = 1'b1;
                            end
                            bufValidD = 1'b0;
                            curByte   = loadByte;
                        end
                        misoD = curByte[7];
                        if (dualQ) begin
                            mosiD     = curByte[6];
                            shiftOutD = {curByte[5:0], 2'b00};
                        end else begin
                            shiftOutD = {curByte[6:0], 1'b0};
                        end
                        bitCntD = (bitCntQ == (dualQ ? CntW'(3) : CntW'(7))) ? '0
                                                                            : bitCntQ + CntW'(1);
                    end
                end
                StIgnore: begin
                    stateD = StIgnore;
                end
                default: begin
                    stateD = StIdle;
                end
            endcase
        end

        if (!memReqQ && !bufValidQ && fetching && !csHigh) begin
            memReqD  = 1'b1;
            memAddrD = addrCntQ;
        end
    end

    always_ff @(posedge C25M) begin
        if (RES) begin
            stateQ    <= StIdle;
            bitCntQ   <= '0;
            shiftInQ  <= '0;
            dualQ     <= 1'b0;
            addrCntQ  <= '0;
            memAddrQ  <= '0;
            memReqQ   <= 1'b0;
            discardQ  <= 1'b0;
            bufQ      <= 8'h00;
            bufValidQ <= 1'b0;
            shiftOutQ <= 8'h00;
            misoQ     <= 1'b1;
            mosiQ     <= 1'b1;
            underrunQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            bitCntQ   <= bitCntD;
            shiftInQ  <= shiftInD;
            dualQ     <= dualD;
            addrCntQ  <= addrCntD;
            memAddrQ  <= memAddrD;
            memReqQ   <= memReqD;
            discardQ  <= discardD;
            bufQ      <= bufD;
            bufValidQ <= bufValidD;
            shiftOutQ <= shiftOutD;
            misoQ     <= misoD;
            mosiQ     <= mosiD;
            underrunQ <= underrunD;
        end
    end

    assign MISOout     = misoQ;
    assign MOSIout     = mosiQ;
    assign MISOOE      = (stateQ == StData);
    assign MOSIOE      = (stateQ == StData) && dualQ;
    assign Busy        = (stateQ != StIdle);
    assign Underrun    = underrunQ;
    assign mem.MemReq  = memReqQ;
    assign mem.MemAddr = memAddrQ;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: an SPI master and a memory model feed expectation queues that
// independent monitors drain as the responder drives its pins and fetch port.
module tb_spi_flash_responder;

    localparam int unsigned AW = 24;
    localparam int H = 6;
    localparam int AMASK = 32'h00FF_FFFF;

    logic C25M = 1'b0;
    logic RES = 1'b1;
    logic nFCS = 1'b1;
    logic FCK = 1'b0;
    logic MOSIin = 1'b0;
    logic MISOout, MISOOE, MOSIout, MOSIOE, Busy, Underrun;

    spi_flash_responder_if #(.ADDR_W(AW)) memIf ();

    spi_flash_responder #(.ADDR_W(AW), .DUMMY_CLKS(8)) dut (
        .C25M     (C25M),
        .RES      (RES),
        .nFCS     (nFCS),
        .FCK      (FCK),
        .MOSIin   (MOSIin),
        .MISOout  (MISOout),
        .MISOOE   (MISOOE),
        .MOSIout  (MOSIout),
        .MOSIOE   (MOSIOE),
        .Busy     (Busy),
        .Underrun (Underrun),
        .mem      (memIf)
    );

    always #5 C25M = ~C25M;

    int testsRun = 0;
    int testsFailed = 0;
    int expAddrQ[$];
    logic [3:0] expBitQ[$];
    bit [7:0] memOvr[int];
    bit sampleEn = 1'b0;
    int holdAddr = -1;
    int holdCycles = 0;

    function automatic bit [7:0] memByte(input int a);
        if (memOvr.exists(a)) return memOvr[a];
        return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input longint act);
        testsRun++;
        testsFailed++;
        $display("FAIL %s: unexpected event, value 0x%0h at %0t", name, act, $time);
    endtask

    // Memory model: checks each fetch address against the scoreboard, then acks.
    initial begin
        int a;
        int lat;
        memIf.MemAck = 1'b0;
        memIf.MemData = 8'h00;
        forever begin
            @(negedge C25M);
            if (memIf.MemReq === 1'b1) begin
                a = int'(memIf.MemAddr);
                if (expAddrQ.size() == 0) unexpected("MemReq", a);
                else check("MemAddr", a, expAddrQ.pop_front());
                lat = (a == holdAddr) ? holdCycles : int'($urandom_range(0, 2));
                repeat (lat) @(negedge C25M);
                check("MemReq held until ack", memIf.MemReq, 1);
                check("MemAddr stable while MemReq", memIf.MemAddr, a);
                memIf.MemData = memByte(a);
                memIf.MemAck = 1'b1;
                @(negedge C25M);
                memIf.MemAck = 1'b0;
            end
        end
    end

    // Pin monitor: the SPI master samples the data pins on every FCK rise in the data phase.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge FCK);
            if (sampleEn) begin
                if (expBitQ.size() == 0) begin
                    unexpected("data sample", {MISOOE, MOSIOE, MISOout, MOSIout});
                end else begin
                    e = expBitQ.pop_front();
                    check("pins {MISOOE,MOSIOE,MISO,MOSI}", {MISOOE, MOSIOE, MISOout, MOSIout}, e);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic spiClk(input bit b, input bit smp);
        MOSIin = b;
        sampleEn = smp;
        repeat (H) @(negedge C25M);
        FCK = 1'b1;
        repeat (H) @(negedge C25M);
        FCK = 1'b0;
    endtask

    task automatic sendBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spiClk(v[i], 1'b0);
    endtask

    task automatic spiStart;
        @(negedge C25M);
        nFCS = 1'b0;
    endtask

    task automatic spiStop;
        repeat (H) @(negedge C25M);
        nFCS = 1'b1;
        sampleEn = 1'b0;
        repeat (8) @(negedge C25M);
    endtask

    // Byte stream follows memory order; an underrun slot sends 0xFF without consuming
    // an address. The master's trailing fall pulls one more byte, so two fetches run ahead.
    task automatic pushRead(input int addr, input int n, input bit dual, input int urSlot);
        int src;
        bit [7:0] b;
        src = addr;
        for (int i = 0; i < n; i++) begin
            if (i == urSlot) begin
                b = 8'hFF;
            end else begin
                b = memByte(src & AMASK);
                src++;
            end
            if (dual) for (int j = 3; j >= 0; j--) expBitQ.push_back({2'b11, b[2*j+1], b[2*j]});
            else for (int j = 7; j >= 0; j--) expBitQ.push_back({2'b10, b[j], 1'b1});
        end
        for (int k = 0; k <= src - addr + 1; k++) expAddrQ.push_back((addr + k) & AMASK);
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 300 && (memIf.MemReq || memIf.MemAck); i++) @(negedge C25M);
        repeat (2) @(negedge C25M);
        check({name, ": MemReq idle"}, memIf.MemReq, 0);
        check({name, ": samples left"}, expBitQ.size(), 0);
        check({name, ": fetches left"}, expAddrQ.size(), 0);
    endtask

    task automatic doRead(input int addr, input int n, input bit dual, input int urSlot);
        pushRead(addr, n, dual, urSlot);
        spiStart();
        sendBits(dual ? 32'h3B : 32'h03, 8);
        sendBits(addr, 24);
        if (dual) repeat (8) spiClk(1'b0, 1'b0);
        repeat (n * (dual ? 4 : 8)) spiClk(1'b0, 1'b1);
        spiStop();
        settle(dual ? "dual read" : "single read");
        check("Busy after read", Busy, 0);
        check("MISOOE after read", MISOOE, 0);
    endtask

    initial begin
        int a;
        repeat (5) @(negedge C25M);
        RES = 1'b0;
        @(negedge C25M);
        check("reset MISOout", MISOout, 1);
        check("reset MOSIout", MOSIout, 1);
        check("reset MISOOE", MISOOE, 0);
        check("reset MOSIOE", MOSIOE, 0);
        check("reset MemReq", memIf.MemReq, 0);
        check("reset MemAddr", memIf.MemAddr, 0);
        check("reset Busy", Busy, 0);
        check("reset Underrun", Underrun, 0);

        memOvr[32'h2000] = 8'hA5;
        memOvr[32'h2001] = 8'h3C;
        memOvr[32'h0010] = 8'h81;
        doRead(32'h002000, 2, 1'b1, -1);
        doRead(32'h000010, 1, 1'b0, -1);

        // Unknown command
        spiStart();
        sendBits(32'h9F, 8);
        repeat (4) spiClk(1'($urandom_range(0, 1)), 1'b0);
        check("ignore Busy", Busy, 1);
        check("ignore MISOOE", MISOOE, 0);
        check("ignore MOSIOE", MOSIOE, 0);
        check("ignore MemReq", memIf.MemReq, 0);
        spiStop();
        check("ignore Busy after nFCS", Busy, 0);

        doRead(32'hFFFFFF, 2, 1'b0, -1);
        check("Underrun clear before stall", Underrun, 0);

        // Late fetch past a byte boundary
        holdAddr = 32'h401;
        holdCycles = 120;
        doRead(32'h400, 3, 1'b0, 1);
        holdAddr = -1;
        check("Underrun after stall", Underrun, 1);
        @(negedge C25M);
        RES = 1'b1;
        repeat (2) @(negedge C25M);
        RES = 1'b0;
        @(negedge C25M);
        check("Underrun after RES", Underrun, 0);
        check("MemAddr after RES", memIf.MemAddr, 0);

        // Abort after 12 address bits
        spiStart();
        sendBits(32'h3B, 8);
        sendBits(32'h123, 12);
        check("Busy mid-address", Busy, 1);
        nFCS = 1'b1;
        repeat (4) @(negedge C25M);
        check("abort Busy", Busy, 0);
        check("abort MemReq", memIf.MemReq, 0);
        repeat (4) @(negedge C25M);
        check("abort fetches", expAddrQ.size(), 0);
        doRead(32'h0ABCDE, 2, 1'b1, -1);

        // Abort with a fetch outstanding
        holdAddr = 32'h055500;
        holdCycles = 150;
        expAddrQ.push_back(32'h055500);
        spiStart();
        sendBits(32'h3B, 8);
        sendBits(32'h055500, 24);
        repeat (3) spiClk(1'b0, 1'b0);
        nFCS = 1'b1;
        repeat (5) @(negedge C25M);
        check("inflight abort Busy", Busy, 0);
        check("inflight abort MISOOE", MISOOE, 0);
        check("inflight abort MOSIOE", MOSIOE, 0);
        check("inflight MemReq held", memIf.MemReq, 1);
        settle("inflight abort");
        holdAddr = -1;
        doRead(32'h055500, 1, 1'b1, -1);

        for (int t = 0; t < 8; t++) begin
            a = (t == 3) ? 32'hFFFFFE : int'($urandom) & AMASK;
            doRead(a, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), -1);
        end
        check("Underrun after clean reads", Underrun, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
